// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the seven-segment scanner
// Purpose: active-low segment patterns {g,f,e,d,c,b,a}, all-off values, and
//          the digit-position enum shared by the scanner and the decoder.
// Ports:   none (package).
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'hF;

  // Digit position on the display; also the adj_sel encoding.
  typedef enum logic [1:0] {
    POS_SEC_R = 2'd0,
    POS_SEC_L = 2'd1,
    POS_MIN_R = 2'd2,
    POS_MIN_L = 2'd3
  } pos_e;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD to active-low seven-segment decoder
// Purpose: combinational decode of one BCD digit; non-BCD codes show a dash.
// Ports:   bcd  in  4  digit value
//          seg  out 7  cathodes {g,f,e,d,c,b,a}, active-low
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - 4-digit common-anode display multiplexer with blink
// Purpose: scans four BCD digits onto one display, snapshotting them once per
//          frame so a frame never tears, blanking the start of every slot to
//          suppress ghosting, and blinking the digit under adjustment.
// Ports:   clk         in  1  system clock
//          rst_n       in  1  asynchronous active-low reset
//          min_l..sec_r in 4  BCD digits from the counter
//          adj         in  1  adjust mode active
//          adj_sel     in  2  digit being adjusted (pos_e encoding)
//          an          out 4  anodes, active-low, an[i] = position i
//          seg         out 7  cathodes {g,f,e,d,c,b,a}, active-low
//          dp          out 1  decimal point, active-low (lit at position 2)
//          frame_done  out 1  one-cycle pulse at each frame boundary
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 262144,
  parameter int BLANK_CYCLES = 1024,
  parameter int BLINK_FRAMES = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] min_l,
  input  logic [3:0] min_r,
  input  logic [3:0] sec_l,
  input  logic [3:0] sec_r,
  input  logic       adj,
  input  logic [1:0] adj_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      snap;   // {min_l, min_r, sec_l, sec_r}
  logic [FC_W-1:0]  fc;
  logic             bl;

  logic       slot_end;
  logic       frame_end;
  logic       blank;
  logic [3:0] digit;
  logic [6:0] dec_seg;

  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == 2'd3);
    // bl is gated by adj here so dropping adj un-blanks on the very next output.
    blank     = (cnt < BLANK_END) || (adj && bl && (idx == adj_sel));
    digit     = snap[3:0];
    case (pos_e'(idx))
      POS_SEC_R: digit = snap[3:0];
      POS_SEC_L: digit = snap[7:4];
      POS_MIN_R: digit = snap[11:8];
      POS_MIN_L: digit = snap[15:12];
      default:   digit = snap[3:0];
    endcase
  end

  seg7_decode u_decode (
    .bcd (digit),
    .seg (dec_seg)
  );

  // Prescaler, slot index and per-frame snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      idx  <= 2'd0;
      snap <= 16'h0000;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx <= idx + 2'd1;
      end
      if (frame_end) begin
        snap <= {min_l, min_r, sec_l, sec_r};
      end
    end
  end

  // Blink phase: held at zero outside adjust mode so the selected digit is
  // first shown for a full half-period when adjust mode is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc <= '0;
      bl <= 1'b0;
    end else if (!adj) begin
      fc <= '0;
      bl <= 1'b0;
    end else if (frame_end) begin
      if (fc == FC_LAST) begin
        fc <= '0;
        bl <= ~bl;
      end else begin
        fc <= fc + 1'b1;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (blank) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= dec_seg;
        dp  <= (pos_e'(idx) != POS_MIN_R);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan
module tb_seg7_scan;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] min_l = 4'd1, min_r = 4'd2, sec_l = 4'd3, sec_r = 4'd4;
  logic       adj = 1'b0;
  logic [1:0] adj_sel = 2'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: cycles since reset release, frame snapshot,
  // and frame boundaries seen while adjust mode has been continuously on.
  int          t = 0;
  logic [15:0] snap_m = 16'h0;
  int          adj_frames = 0;
  logic [6:0]  seg_tab [16];

  seg7_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .min_l      (min_l),
    .min_r      (min_r),
    .sec_l      (sec_l),
    .sec_r      (sec_r),
    .adj        (adj),
    .adj_sel    (adj_sel),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    t = 0;
    snap_m = 16'h0;
    adj_frames = 0;
  endtask

  // One clock: predict the registered outputs from the inputs present at the
  // edge, then compare 1 time unit after the edge and advance the model.
  task automatic step();
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed, ef, bl, blk;
    int         p, slot;
    if (!rst_n) begin
      ea = 4'hF; es = 7'h7F; ed = 1'b1; ef = 1'b0;
    end else begin
      p    = t % SCAN_DIV;
      slot = (t / SCAN_DIV) % 4;
      bl   = adj && (((adj_frames / BLINK_FRAMES) % 2) == 1);
      blk  = (p < BLANK_CYCLES) || (bl && slot == int'(adj_sel));
      ef   = (p == SCAN_DIV - 1) && (slot == 3);
      if (blk) begin
        ea = 4'hF; es = 7'h7F; ed = 1'b1;
      end else begin
        ea = 4'hF;
        ea[slot] = 1'b0;
        es = seg_tab[snap_m[slot*4 +: 4]];
        ed = (slot != 2);
      end
    end
    @(posedge clk);
    #1;
    chk("an", {4'h0, an}, {4'h0, ea});
    chk("seg", {1'b0, seg}, {1'b0, es});
    chk("dp", {7'h0, dp}, {7'h0, ed});
    chk("frame_done", {7'h0, frame_done}, {7'h0, ef});
    if (rst_n) begin
      if (ef) snap_m = {min_l, min_r, sec_l, sec_r};
      if (!adj) adj_frames = 0;
      else if (ef) adj_frames++;
      t++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic align_frame();
    while (t % FRAME != 0) step();
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    // Reset held: outputs at reset values.
    run(3);
    #2 rst_n = 1'b1;

    // First frame shows snap=0, second frame shows 1,2,3,4.
    run(2 * FRAME);

    // Tear check: sec_r changes during slot 2.
    while ((t % FRAME) / SCAN_DIV != 2) step();
    sec_r = 4'd9;
    run(2 * FRAME);

    // Invalid BCD on sec_l.
    sec_l = 4'hC;
    run(2 * FRAME);

    // Blink on position 2 over six frames from a frame boundary.
    align_frame();
    adj = 1'b1;
    adj_sel = 2'd2;
    run(6 * FRAME);

    // Re-enter adjust mode, drop it during slot 2 of frame 3.
    adj = 1'b0;
    align_frame();
    adj = 1'b1;
    run(3 * FRAME + 2 * SCAN_DIV + 1);
    adj = 1'b0;
    run(FRAME);

    // Randomized digits, adjust toggles and selection.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) min_l = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) min_r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) sec_l = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) sec_r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 47) == 0) adj = ~adj;
      if ($urandom_range(0, 63) == 0) adj_sel = 2'($urandom_range(0, 3));
      step();
    end

    // Asynchronous reset mid-slot: outputs change before the next edge.
    align_frame();
    run(SCAN_DIV + 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", {4'h0, an}, 8'h0F);
    chk("async_seg", {1'b0, seg}, 8'h7F);
    chk("async_dp", {7'h0, dp}, 8'h01);
    chk("async_fd", {7'h0, frame_done}, 8'h00);
    model_reset();
    run(2);
    #2 rst_n = 1'b1;
    run(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
